// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the direct-mapped write-back data cache.
package dcache_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} dcache_state_t;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU data port plus word-wide memory handshake port of the data cache.
interface dcache_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              re;
  logic              we;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              d_rdy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  addr, re, we, wr_data, mem_rdata, mem_ack,
    output rd_data, d_rdy, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output addr, re, we, wr_data, mem_rdata, mem_ack,
    input  rd_data, d_rdy, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_tag_array.sv
// Tag/valid/dirty store: async read by index, sync update; valid and dirty clear on reset.
module dcache_tag_array #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx_i,
  output logic [TAG_W-1:0]   tag_o,
  output logic               valid_o,
  output logic               dirty_o,
  input  logic               tag_we_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               set_valid_i,
  input  logic               clr_dirty_i,
  input  logic               set_dirty_i
);
  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0] tag_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  always_ff @(posedge clk) begin
    if (tag_we_i) tag_q[idx_i] <= tag_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (set_valid_i) valid_q[idx_i] <= 1'b1;
      if (clr_dirty_i)      dirty_q[idx_i] <= 1'b0;
      else if (set_dirty_i) dirty_q[idx_i] <= 1'b1;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache with line WB/FILL controller.
// Optional hit/miss/write-back counters when DCACHE_STATS_EN is defined.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64
) (
  input  logic clk,
  input  logic rst,
`ifdef DCACHE_STATS_EN
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt,
  output logic [STAT_W-1:0] wb_cnt,
`endif
  dcache_ctrl_if.slave bus
);
  localparam int OFFSET_W = $clog2(LINE_WORDS);
  localparam int INDEX_W  = $clog2(LINES);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);
  localparam logic [OFFSET_W-1:0] BEAT0     = '0;

  logic [TAG_W-1:0]    tag, vtag;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  assign {tag, idx, off} = bus.addr;

  dcache_state_t       state_q;
  logic [OFFSET_W-1:0] beat_q, beat_nx;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   data_q [LINES*LINE_WORDS];

  logic v_valid, v_dirty, hit, req, idle, wr_hit, fill_ack, fill_last;

  assign req       = bus.re | bus.we;
  assign idle      = (state_q == IDLE);
  assign hit       = v_valid & (vtag == tag);
  assign wr_hit    = idle & bus.we & hit;
  assign fill_ack  = (state_q == FILL) & bus.mem_ack;
  assign fill_last = fill_ack & (beat_q == LAST_BEAT);
  assign beat_nx   = beat_q + 1'b1;

  assign bus.d_rdy     = idle & (hit | ~req);
  assign bus.rd_data   = (idle & bus.re & ~bus.we & hit) ? data_q[{idx, off}] : '0;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  dcache_tag_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_tags (
    .clk         (clk),
    .rst         (rst),
    .idx_i       (idx),
    .tag_o       (vtag),
    .valid_o     (v_valid),
    .dirty_o     (v_dirty),
    .tag_we_i    (fill_last),
    .tag_i       (tag),
    .set_valid_i (fill_last),
    .clr_dirty_i (fill_last),
    .set_dirty_i (wr_hit)
  );

  // Data storage is not reset; only a valid tag ever exposes it.
  always_ff @(posedge clk) begin
    if (wr_hit)        data_q[{idx, off}]    <= bus.wr_data;
    else if (fill_ack) data_q[{idx, beat_q}] <= bus.mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req & ~hit) begin
          beat_q    <= '0;
          mem_req_q <= 1'b1;
          if (v_valid & v_dirty) begin
            state_q     <= WB;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {vtag, idx, BEAT0};
            mem_wdata_q <= data_q[{idx, BEAT0}];
          end else begin
            state_q    <= FILL;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag, idx, BEAT0};
          end
        end
        WB: if (bus.mem_ack) begin
          beat_q <= beat_nx;
          // Last victim beat flows straight into the fill with req held high.
          if (beat_q == LAST_BEAT) begin
            state_q    <= FILL;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag, idx, BEAT0};
          end else begin
            mem_addr_q  <= {vtag, idx, beat_nx};
            mem_wdata_q <= data_q[{idx, beat_nx}];
          end
        end
        FILL: if (bus.mem_ack) begin
          beat_q <= beat_nx;
          if (beat_q == LAST_BEAT) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
          end else begin
            mem_addr_q <= {tag, idx, beat_nx};
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic              after_done_q;
  logic [STAT_W-1:0] hit_q, miss_q, wb_q;

  // The retried access right after DONE belongs to the miss, not a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      after_done_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
      wb_q         <= '0;
    end else begin
      after_done_q <= (state_q == DONE);
      if (idle & req & hit & ~after_done_q) hit_q <= sat_inc(hit_q);
      if (idle & req & ~hit) begin
        miss_q <= sat_inc(miss_q);
        if (v_valid & v_dirty) wb_q <= sat_inc(wb_q);
      end
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
  assign wb_cnt   = wb_q;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench: vector table for CPU accesses, beat scoreboard on the memory port.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  dcache_ctrl #(.ADDR_W(16), .DATA_W(16), .LINE_WORDS(4), .LINES(64)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef DCACHE_STATS_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt),
`endif
    .bus      (bus)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  typedef struct {
    logic        re, we;
    logic [15:0] addr, wdata;
    logic        miss, wb;
    logic [7:0]  vtag;
    logic [15:0] exp_rd;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  beat_t exp_q[$];
  logic [15:0] mem_m [logic [15:0]];
  logic [15:0] cpu_m [logic [15:0]];
  vec_t vt [11];

  logic        skip_stab;
  int          dly = 0;
  logic        pend = 1'b0;
  logic        s_we;
  logic [15:0] s_addr, s_wd;
  beat_t       rb;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem_m.exists(a) ? mem_m[a] : init_val(a);
  endfunction

  function automatic logic [15:0] cpu_rd(input logic [15:0] a);
    return cpu_m.exists(a) ? cpu_m[a] : init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_line(input logic we, input logic [13:0] line);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.we   = we;
      b.addr = {line, 2'(i)};
      b.data = we ? cpu_rd(b.addr) : 16'h0;
      exp_q.push_back(b);
    end
  endtask

  // Memory responder: random 0-5 cycle ack delay, scoreboard pop, stability check.
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ack = 1'b0;
      dly  = 0;
      pend = 1'b0;
    end else begin
      bus.mem_ack = 1'b0;
      if (!skip_stab && pend && bus.mem_req) begin
        chk("stable mem_addr", bus.mem_addr, s_addr);
        chk("stable mem_we", bus.mem_we, s_we);
        chk("stable mem_wdata", bus.mem_wdata, s_wd);
      end
      if (bus.mem_req) begin
        if (dly == 0) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected beat: mem_addr %0h with empty scoreboard", bus.mem_addr);
          end else begin
            n_vec--;
            rb = exp_q.pop_front();
            chk("beat mem_we", bus.mem_we, rb.we);
            chk("beat mem_addr", bus.mem_addr, rb.addr);
            if (rb.we) chk("beat mem_wdata", bus.mem_wdata, rb.data);
          end
          if (bus.mem_we) mem_m[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata = mem_rd(bus.mem_addr);
          bus.mem_ack = 1'b1;
          dly = $urandom_range(0, 5);
        end else begin
          dly--;
        end
      end
      pend   = bus.mem_req && !bus.mem_ack;
      s_addr = bus.mem_addr;
      s_we   = bus.mem_we;
      s_wd   = bus.mem_wdata;
    end
  end

  task automatic wait_done(input string nm, input logic [15:0] exp_rd);
    logic prev_req, prev_rdy, done, seen_req;
    prev_req = 1'b0; prev_rdy = 1'b0; done = 1'b0; seen_req = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      prev_req = bus.mem_req;
      prev_rdy = bus.d_rdy;
      @(negedge clk); #1;
      skip_stab = 1'b0;
      if (bus.mem_req) seen_req = 1'b1;
      if (bus.d_rdy) done = 1'b1;
    end
    chk({nm, " completes"}, done, 1);
    chk({nm, " saw mem_req"}, seen_req, 1);
    chk({nm, " DONE bubble"}, {prev_req, prev_rdy}, 2'b00);
    chk({nm, " beats left"}, exp_q.size(), 0);
    chk({nm, " rd_data"}, bus.rd_data, exp_rd);
  endtask

  task automatic do_access(input vec_t v, input string nm);
    @(negedge clk);
    bus.re = v.re; bus.we = v.we; bus.addr = v.addr; bus.wr_data = v.wdata;
    if (v.miss) begin
      if (v.wb) push_line(1'b1, {v.vtag, v.addr[7:2]});
      push_line(1'b0, v.addr[15:2]);
    end
    #1;
    chk({nm, " d_rdy"}, bus.d_rdy, !v.miss);
    chk({nm, " mem_req"}, bus.mem_req, 0);
    if (v.miss) wait_done(nm, v.exp_rd);
    else        chk({nm, " rd_data"}, bus.rd_data, v.exp_rd);
    if (v.we) cpu_m[v.addr] = v.wdata;
    @(negedge clk);
    bus.re = 1'b0; bus.we = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bool_init: begin
      bus.re = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wr_data = '0;
      skip_stab = 1'b0;
    end
    //          re    we    addr      wdata     miss  wb    vtag   exp_rd
    vt[0]  = '{1'b1, 1'b0, 16'h0041, 16'h0000, 1'b1, 1'b0, 8'h00, init_val(16'h0041)};
    vt[1]  = '{1'b0, 1'b1, 16'h0042, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000};
    vt[2]  = '{1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0, 8'h00, 16'hBEEF};
    vt[3]  = '{1'b1, 1'b0, 16'h1042, 16'h0000, 1'b1, 1'b1, 8'h00, init_val(16'h1042)};
    vt[4]  = '{1'b0, 1'b1, 16'h2043, 16'h1234, 1'b1, 1'b0, 8'h10, 16'h0000};
    vt[5]  = '{1'b1, 1'b0, 16'h2043, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h1234};
    vt[6]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b1, 8'h20, init_val(16'h0040)};
    vt[7]  = '{1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0, 8'h00, 16'hBEEF};
    vt[8]  = '{1'b1, 1'b0, 16'h3FFF, 16'h0000, 1'b1, 1'b0, 8'h00, init_val(16'h3FFF)};
    vt[9]  = '{1'b1, 1'b1, 16'h3FFC, 16'h7777, 1'b0, 1'b0, 8'h00, 16'h0000};
    vt[10] = '{1'b1, 1'b0, 16'h3FFC, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h7777};

    #12;
    chk("reset mem_req", bus.mem_req, 0);
    chk("reset mem_we", bus.mem_we, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset mem_wdata", bus.mem_wdata, 0);
    chk("reset d_rdy", bus.d_rdy, 1);
    chk("reset rd_data", bus.rd_data, 0);
`ifdef DCACHE_STATS_EN
    chk("reset hit_cnt", hit_cnt, 0);
    chk("reset miss_cnt", miss_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_access(vt[i], $sformatf("v%0d", i));
`ifdef DCACHE_STATS_EN
      if (i == 3) begin
        chk("stats hit_cnt", hit_cnt, 2);
        chk("stats miss_cnt", miss_cnt, 2);
        chk("stats wb_cnt", wb_cnt, 1);
      end
`endif
    end

    // Reset pulse while beat 2 of a cold fill is outstanding.
    @(negedge clk);
    skip_stab = 1'b1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    cpu_m = mem_m;
    rst = 1'b0;
    @(negedge clk);
    bus.re = 1'b1; bus.addr = 16'h1042;
    push_line(1'b0, 14'h0410);
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(negedge clk); #1;
        if (bus.mem_req && bus.mem_addr == 16'h1042) seen = 1'b1;
      end
      chk("rst reached beat 2", seen, 1);
    end
    skip_stab = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst drops mem_req", bus.mem_req, 0);
    chk("rst miss stalls", bus.d_rdy, 0);
    exp_q.delete();
    push_line(1'b0, 14'h0410);
    #1;
    rst = 1'b0;
    wait_done("refill", mem_rd(16'h1042));
    @(negedge clk);
    bus.re = 1'b0;

`ifdef DCACHE_STATS_EN
    chk("post-rst miss_cnt", miss_cnt, 1);
    chk("post-rst hit_cnt", hit_cnt, 0);
    @(negedge clk);
    bus.re = 1'b1; bus.addr = 16'h1041;
    repeat (65540) @(negedge clk);
    #1;
    chk("sat hit_cnt", hit_cnt, 16'hFFFF);
    chk("sat miss_cnt", miss_cnt, 1);
    bus.re = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
